// File: rtl/regfile_sb_pkg.sv
// Shared register-file sizing for the regfile and decode.
// Holds the size defaults, the hardwired-zero register index and the address-width derivation.
package regfile_sb_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned NRD_DEF   = 2;
   localparam int unsigned REG0      = 0;

   // Decode derives its register-specifier width from this same function.
   function automatic int unsigned addr_width(input int unsigned nregs);
      return $clog2(nregs);
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the register file.
// The master drives reads, reserves and writebacks; the slave is the register file.
interface regfile_sb_if
   import regfile_sb_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned NRD   = NRD_DEF
);
   localparam int unsigned AW = addr_width(NREGS);

   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_valid;
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic [NREGS-1:0]    busy_vec;

   modport master (
      output rd_en, rd_addr, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
      input  rd_data, rd_valid, busy_vec
   );

   modport slave (
      input  rd_en, rd_addr, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
      output rd_data, rd_valid, busy_vec
   );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits: set by reserve, cleared by writeback.
// When both hit the same register, the reserve wins because a new producer is pending.
module regfile_scoreboard
   import regfile_sb_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   localparam int unsigned AW   = addr_width(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rsv_en_i,
   input  logic [AW-1:0]    rsv_addr_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   output logic [NREGS-1:0] busy_o
);
   localparam logic [AW-1:0] ADDR0 = AW'(REG0);

   logic [NREGS-1:0] busy_d, busy_q;

   // NOTE: combinational next-state uses blocking '=' and assigns a default first, so no latch is inferred.
   always_comb begin
      busy_d = busy_q;
      if (wr_en_i && wr_addr_i != ADDR0)   busy_d[wr_addr_i]  = 1'b0;
      if (rsv_en_i && rsv_addr_i != ADDR0) busy_d[rsv_addr_i] = 1'b1;
      busy_d[REG0] = 1'b0;
   end

   // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with busy scoreboard and write->read bypass.
// Reads take one cycle; rd_valid is low while the addressed register awaits its producer.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned NRD   = NRD_DEF
) (
   input  logic      clk,
   input  logic      reset,
   regfile_sb_if.slave bus
);
   localparam int unsigned   AW    = addr_width(NREGS);
   localparam logic [AW-1:0] ADDR0 = AW'(REG0);

   logic [XLEN-1:0]  mem_q [NREGS];
   logic [NREGS-1:0] busy;

   regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .rsv_en_i   (bus.rsv_en),
      .rsv_addr_i (bus.rsv_addr),
      .wr_en_i    (bus.wr_en),
      .wr_addr_i  (bus.wr_addr),
      .busy_o     (busy)
   );

   assign bus.busy_vec = busy;

   // NOTE: the storage array is reset because a mid-run reset must discard all register contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
      end else if (bus.wr_en && bus.wr_addr != ADDR0) begin
         mem_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   for (genvar p = 0; p < int'(NRD); p++) begin : g_port
      logic [AW-1:0]   addr;
      logic            wr_hit;
      logic [XLEN-1:0] data_d, data_q;
      logic            valid_d, valid_q;

      assign addr = bus.rd_addr[p*AW +: AW];

      // A same-cycle writeback both forwards its data and makes the operand ready.
      always_comb begin
         wr_hit  = bus.wr_en && (bus.wr_addr == addr);
         data_d  = mem_q[addr];
         valid_d = ~busy[addr];
         if (wr_hit) begin
            data_d  = bus.wr_data;
            valid_d = 1'b1;
         end
         if (addr == ADDR0) begin
            data_d  = '0;
            valid_d = 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else if (bus.rd_en[p]) begin
            data_q  <= data_d;
            valid_q <= valid_d;
         end
      end

      assign bus.rd_data[p*XLEN +: XLEN] = data_q;
      assign bus.rd_valid[p]             = valid_q;
   end

endmodule
